// File: rtl/bsg_dmc_pkg.sv
// Shared types for the DMC clock configuration path: tag-client command ids, DS payload packing, sequencer state/step encodings.
package bsg_dmc_pkg;

  typedef enum logic [2:0] {
    ASYNC_RST,
    OSC_RST,
    DS,
    DLY,
    DLY_TRIG,
    OSC,
    OSC_TRIG,
    MON_DS
  } bsg_dmc_cfg_cmd_e;

  typedef struct packed {
    logic       reset;
    logic [1:0] val;
  } bsg_dmc_ds_s;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } bsg_dmc_seq_state_e;

  typedef enum logic [3:0] {
    STEP_ARST_ON,
    STEP_OSC_RST_ON,
    STEP_DS_RESET,
    STEP_DLY,
    STEP_DLY_TRIG,
    STEP_OSC,
    STEP_OSC_TRIG,
    STEP_OSC_RST_OFF,
    STEP_DS_RUN,
    STEP_MON_DS,
    STEP_ARST_OFF
  } bsg_dmc_seq_step_e;

  function automatic int bsg_dmc_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic bsg_dmc_ds_s bsg_dmc_ds_pack(input logic reset, input logic [1:0] val);
    bsg_dmc_ds_s ds;
    ds.reset = reset;
    ds.val   = val;
    return ds;
  endfunction

endpackage

// File: rtl/bsg_dmc_clk_cfg_seq.sv
// Sequences DQS delay-line and oscillator programming commands to the tag master; each command holds until yumi, then one idle cycle.
// Define BSG_DMC_CLK_CFG_SEQ_MONITOR_EN to insert the clock-monitor downsample command before async reset release.
module bsg_dmc_clk_cfg_seq
  import bsg_dmc_pkg::*;
#(
  parameter int num_lines_p    = 4,
  parameter int dly_width_p    = 8,
  parameter int osc_width_p    = 8,
  parameter int wait_cycles_p  = 16,
  parameter int data_width_p   = bsg_dmc_max3(dly_width_p, osc_width_p, 3),
  localparam int idx_width_lp  = (num_lines_p > 1) ? $clog2(num_lines_p) : 1,
  localparam int wait_width_lp = (wait_cycles_p > 0) ? $clog2(wait_cycles_p + 1) : 1
)(
  input  logic                                   clk_i,
  input  logic                                   async_reset_i,
  input  logic                                   start_i,
  input  logic [num_lines_p-1:0][dly_width_p-1:0] dly_val_i,
  input  logic [osc_width_p-1:0]                 osc_val_i,
  input  logic [1:0]                             mon_ds_val_i,
  output logic                                   cmd_v_o,
  output bsg_dmc_cfg_cmd_e                       cmd_id_o,
  output logic [idx_width_lp-1:0]                cmd_idx_o,
  output logic [data_width_p-1:0]                cmd_data_o,
  input  logic                                   cmd_yumi_i,
  output logic                                   busy_o,
  output logic                                   done_o
);

  bsg_dmc_seq_state_e state_r, state_n;
  bsg_dmc_seq_step_e  step_r, step_n;
  logic [idx_width_lp-1:0]                line_r, line_n;
  logic [wait_width_lp-1:0]               wait_cnt_r, wait_cnt_n;
  logic                                   cmd_v_r, cmd_v_n;
  logic [num_lines_p-1:0][dly_width_p-1:0] dly_r, dly_n;
  logic [osc_width_p-1:0]                 osc_r, osc_n;
`ifdef BSG_DMC_CLK_CFG_SEQ_MONITOR_EN
  logic [1:0]                             mon_r, mon_n;
`else
  logic                                   unused_mon_ds;
  assign unused_mon_ds = ^mon_ds_val_i;
`endif

  logic last_line;
  assign last_line = (line_r == idx_width_lp'(num_lines_p - 1));

  always_ff @(posedge clk_i or posedge async_reset_i) begin
    if (async_reset_i) begin
      state_r    <= IDLE;
      step_r     <= STEP_ARST_ON;
      line_r     <= '0;
      wait_cnt_r <= '0;
      cmd_v_r    <= 1'b0;
      dly_r      <= '0;
      osc_r      <= '0;
`ifdef BSG_DMC_CLK_CFG_SEQ_MONITOR_EN
      mon_r      <= '0;
`endif
    end else begin
      state_r    <= state_n;
      step_r     <= step_n;
      line_r     <= line_n;
      wait_cnt_r <= wait_cnt_n;
      cmd_v_r    <= cmd_v_n;
      dly_r      <= dly_n;
      osc_r      <= osc_n;
`ifdef BSG_DMC_CLK_CFG_SEQ_MONITOR_EN
      mon_r      <= mon_n;
`endif
    end
  end

  always_comb begin
    state_n    = state_r;
    step_n     = step_r;
    line_n     = line_r;
    wait_cnt_n = wait_cnt_r;
    cmd_v_n    = cmd_v_r;
    dly_n      = dly_r;
    osc_n      = osc_r;
`ifdef BSG_DMC_CLK_CFG_SEQ_MONITOR_EN
    mon_n      = mon_r;
`endif
    case (state_r)
      IDLE, DONE: begin
        if (start_i) begin
          state_n    = ISSUE;
          step_n     = STEP_ARST_ON;
          line_n     = '0;
          wait_cnt_n = '0;
          cmd_v_n    = 1'b1;
          dly_n      = dly_val_i;
          osc_n      = osc_val_i;
`ifdef BSG_DMC_CLK_CFG_SEQ_MONITOR_EN
          mon_n      = mon_ds_val_i;
`endif
        end
      end
      ISSUE: begin
        if (!cmd_v_r) begin
          cmd_v_n = 1'b1;
        end else if (cmd_yumi_i) begin
          // Valid drops for one cycle after every handshake; the next step is presented after that bubble.
          cmd_v_n = 1'b0;
          case (step_r)
            STEP_ARST_ON:    step_n = STEP_OSC_RST_ON;
            STEP_OSC_RST_ON: step_n = STEP_DS_RESET;
            STEP_DS_RESET:   step_n = STEP_DLY;
            STEP_DLY:        step_n = STEP_DLY_TRIG;
            STEP_DLY_TRIG: begin
              if (last_line) begin
                step_n = STEP_OSC;
                line_n = '0;
              end else begin
                step_n = STEP_DLY;
                line_n = line_r + idx_width_lp'(1);
              end
            end
            STEP_OSC:        step_n = STEP_OSC_TRIG;
            STEP_OSC_TRIG:   step_n = STEP_OSC_RST_OFF;
            STEP_OSC_RST_OFF: begin
              step_n = STEP_DS_RUN;
              if (wait_cycles_p > 0) begin
                state_n    = WAIT;
                wait_cnt_n = wait_width_lp'(wait_cycles_p);
              end
            end
`ifdef BSG_DMC_CLK_CFG_SEQ_MONITOR_EN
            STEP_DS_RUN:     step_n = STEP_MON_DS;
            STEP_MON_DS:     step_n = STEP_ARST_OFF;
`else
            STEP_DS_RUN:     step_n = STEP_ARST_OFF;
`endif
            STEP_ARST_OFF:   state_n = DONE;
            default:         state_n = IDLE;
          endcase
        end
      end
      WAIT: begin
        wait_cnt_n = wait_cnt_r - wait_width_lp'(1);
        if (wait_cnt_r == wait_width_lp'(1)) state_n = ISSUE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cmd_id_o   = ASYNC_RST;
    cmd_idx_o  = '0;
    cmd_data_o = '0;
    case (step_r)
      STEP_ARST_ON:     begin cmd_id_o = ASYNC_RST; cmd_data_o = data_width_p'(1); end
      STEP_OSC_RST_ON:  begin cmd_id_o = OSC_RST;   cmd_data_o = data_width_p'(1); end
      STEP_DS_RESET:    begin cmd_id_o = DS;        cmd_data_o = data_width_p'(bsg_dmc_ds_pack(1'b1, 2'b00)); end
      STEP_DLY: begin
        cmd_id_o   = DLY;
        cmd_idx_o  = (num_lines_p > 1) ? line_r : '0;
        cmd_data_o = data_width_p'(dly_r[line_r]);
      end
      STEP_DLY_TRIG: begin
        cmd_id_o   = DLY_TRIG;
        cmd_idx_o  = (num_lines_p > 1) ? line_r : '0;
        cmd_data_o = data_width_p'(1);
      end
      STEP_OSC:         begin cmd_id_o = OSC;       cmd_data_o = data_width_p'(osc_r); end
      STEP_OSC_TRIG:    begin cmd_id_o = OSC_TRIG;  cmd_data_o = data_width_p'(1); end
      STEP_OSC_RST_OFF: begin cmd_id_o = OSC_RST;   cmd_data_o = '0; end
      STEP_DS_RUN:      begin cmd_id_o = DS;        cmd_data_o = data_width_p'(bsg_dmc_ds_pack(1'b0, 2'b00)); end
`ifdef BSG_DMC_CLK_CFG_SEQ_MONITOR_EN
      STEP_MON_DS:      begin cmd_id_o = MON_DS;    cmd_data_o = data_width_p'(bsg_dmc_ds_pack(1'b0, mon_r)); end
`endif
      STEP_ARST_OFF:    begin cmd_id_o = ASYNC_RST; cmd_data_o = '0; end
      default: begin
        cmd_id_o   = ASYNC_RST;
        cmd_data_o = '0;
      end
    endcase
  end

  assign cmd_v_o = cmd_v_r;
  assign busy_o  = (state_r == ISSUE) || (state_r == WAIT);
  assign done_o  = (state_r == DONE);

endmodule

// File: doc/bsg_dmc_clk_cfg_seq.md
BSG_DMC_CLK_CFG_SEQ -- requirements
Module: bsg_dmc_clk_cfg_seq

Interface
REQ-001 SHALL have parameter num_lines_p, default 4: number of DQS delay lines to program.
REQ-002 SHALL have parameter dly_width_p, default 8: delay-line setting width.
REQ-003 SHALL have parameter osc_width_p, default 8: oscillator setting width.
REQ-004 SHALL have parameter wait_cycles_p, default 16: settle cycles after oscillator reset release; 0 = no wait.
REQ-005 SHALL have parameter data_width_p, default max(dly_width_p, osc_width_p, 3): command payload width.
REQ-006 SHALL have port clk_i, input, 1: single clock; all logic is in this domain.
REQ-007 SHALL have port async_reset_i, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port start_i, input, 1: begin configuration sequence.
REQ-009 SHALL have port dly_val_i, input, num_lines_p x dly_width_p: per-line delay settings.
REQ-010 SHALL have port osc_val_i, input, osc_width_p: oscillator setting.
REQ-011 SHALL have port mon_ds_val_i, input, 2: clock-monitor downsample value.
REQ-012 SHALL have port cmd_v_o, output, 1: command valid.
REQ-013 SHALL have port cmd_id_o, output, bsg_dmc_cfg_cmd_e: target tag client.
REQ-014 SHALL have port cmd_idx_o, output, clog2(num_lines_p): delay-line index, 0 for other commands.
REQ-015 SHALL have port cmd_data_o, output, data_width_p: zero-extended payload.
REQ-016 SHALL have port cmd_yumi_i, input, 1: downstream tag master consumes the command.
REQ-017 SHALL have port busy_o, output, 1: sequence in progress.
REQ-018 SHALL have port done_o, output, 1: sequence complete.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-020 SHALL register dly_val_i, osc_val_i and mon_ds_val_i only when start_i is accepted in IDLE or DONE; later input changes SHALL have no effect.
REQ-021 SHALL ignore start_i while busy_o=1.
REQ-022 SHALL issue commands in this fixed order:
- ASYNC_RST=1, OSC_RST=1, DS={reset=1,val=0};
- then, for i=0..num_lines_p-1: DLY[i]=dly_val, then DLY_TRIG[i]=1;
- then OSC=osc_val, OSC_TRIG=1, OSC_RST=0;
- then WAIT;
- then DS={reset=0,val=0}, [MON_DS], ASYNC_RST=0.
REQ-023 SHALL hold cmd_v_o, cmd_id_o, cmd_idx_o and cmd_data_o stable from assertion until the cycle cmd_yumi_i=1.
REQ-024 SHALL present the next command in the cycle after a yumi (one bubble per command).
REQ-025 SHALL ignore cmd_yumi_i while cmd_v_o=0.
REQ-026 SHALL assert cmd_v_o in the cycle after start is accepted.
REQ-027 WAIT SHALL count exactly wait_cycles_p cycles with cmd_v_o=0, then resume ISSUE.
REQ-028 With wait_cycles_p=0, SHALL go directly from OSC_RST=0 to DS.
REQ-029 WAIT counter width SHALL be clog2(wait_cycles_p+1).
REQ-030 After yumi of ASYNC_RST=0, SHALL enter DONE: busy_o=0, done_o=1.
REQ-031 done_o SHALL hold until the next accepted start_i, which clears it on the next cycle.
REQ-032 busy_o SHALL be 1 in ISSUE and WAIT only.
REQ-033 When num_lines_p=1, cmd_idx_o SHALL be 1 bit wide, tied to 0.

Reset
REQ-034 async_reset_i SHALL force IDLE, cmd_v_o=0, busy_o=0, done_o=0 and clear all counters and captured values, at any time including mid-sequence and mid-handshake.
REQ-035 After reset release, no command SHALL issue until start_i.

Configuration
REQ-036 With BSG_DMC_CLK_CFG_SEQ_MONITOR_EN defined, SHALL issue MON_DS={reset=0,val=mon_ds_val} between DS and ASYNC_RST=0.
REQ-037 Without BSG_DMC_CLK_CFG_SEQ_MONITOR_EN, SHALL omit MON_DS; mon_ds_val_i SHALL remain a port, unused.

Structure
REQ-038 bsg_dmc_pkg SHALL hold enum bsg_dmc_cfg_cmd_e: ASYNC_RST, OSC_RST, DS, DLY, DLY_TRIG, OSC, OSC_TRIG, MON_DS.
REQ-039 bsg_dmc_pkg SHALL hold DS payload packing {reset, val[1:0]}.
REQ-040 SHALL be a single module with no sub-module; step counter, line counter and wait counter are inline.

Verification
REQ-041 Bench SHALL cover: num_lines_p=2, macro off, yumi tied 1, start pulse -> 12 commands in REQ-022 order, 16-cycle gap after OSC_RST=0, done_o=1 at end.
REQ-042 Bench SHALL cover: macro on, mon_ds_val_i=2'b01 -> 13 commands; MON_DS data=3'b001 precedes ASYNC_RST=0.
REQ-043 Bench SHALL cover: random yumi stalls of 0-5 cycles -> command fields stable during stall, identical command sequence.
REQ-044 Bench SHALL cover: dly_val_i={8'h22,8'h11}, changed after start -> DLY[0]=8'h11, DLY[1]=8'h22.
REQ-045 Bench SHALL cover: async_reset_i pulsed during DLY_TRIG[1] stall -> cmd_v_o=0 immediately, IDLE; new start restarts from ASYNC_RST=1.
REQ-046 Bench SHALL cover: start_i high while busy_o=1, and wait_cycles_p=0 -> start ignored; no cmd_v_o gap between OSC_RST=0 and DS beyond the one-cycle bubble.
